// File: rtl/phy_pkg.sv
// rtl/phy_pkg.sv - shared PHY link constants, state encoding and byte decode helper
//
// Purpose: definitions common to the serializer and the deserializer sides
//          of the two-lane PHY link.
// Ports:   none (package).
package phy_pkg;

   localparam int unsigned BYTE_W = 8;

   // Default line characters
   localparam logic [BYTE_W-1:0] COMMA_DEF = 8'hBC;  // alignment / inactive
   localparam logic [BYTE_W-1:0] IDLE_DEF  = 8'h7C;  // active, no data

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      LOCKING = 2'd1,
      ACTIVE  = 2'd2
   } phy_state_t;

   // A byte carries payload only if it is neither a comma nor an idle
   function automatic logic is_data(input logic [BYTE_W-1:0] b,
                                    input logic [BYTE_W-1:0] comma,
                                    input logic [BYTE_W-1:0] idle);
      return (b != comma) && (b != idle);
   endfunction

endpackage

// File: rtl/phy_rx_aligner.sv
// rtl/phy_rx_aligner.sv - serial shift register, comma hunt and byte lock FSM
//
// Purpose: shifts in the serial stream, hunts bit-by-bit for the comma,
//          confirms alignment over COMMA_COUNT byte-aligned commas and then
//          stays locked until reset.
// Ports:
//   clk_8f      in   bit clock
//   rst_n       in   asynchronous active-low reset
//   i_data      in   serial data, MSB first
//   o_rx_byte   out  last eight received bits including the current one
//   o_boundary  out  current edge completes a byte (bit counter at 7)
//   o_active    out  link locked (state ACTIVE)
module phy_rx_aligner
   import phy_pkg::*;
#(
   parameter logic [BYTE_W-1:0] COMMA       = COMMA_DEF,
   parameter int unsigned       COMMA_COUNT = 4
) (
   input  logic              clk_8f,
   input  logic              rst_n,
   input  logic              i_data,
   output logic [BYTE_W-1:0] o_rx_byte,
   output logic              o_boundary,
   output logic              o_active
);

   logic [BYTE_W-1:0] r_shift;
   logic [2:0]        r_bit_cnt;
   logic [7:0]        r_comma_cnt;
   phy_state_t        r_state;

   logic [BYTE_W-1:0] w_byte_nx;
   logic [7:0]        w_cnt_inc;
   logic              w_boundary;
   logic              w_is_comma;

   assign w_byte_nx  = {r_shift[BYTE_W-2:0], i_data};
   assign w_cnt_inc  = r_comma_cnt + 8'd1;
   assign w_boundary = (r_bit_cnt == 3'd7);
   assign w_is_comma = (w_byte_nx == COMMA);

   always_ff @(posedge clk_8f or negedge rst_n) begin
      if (!rst_n) begin
         r_shift     <= '0;
         r_bit_cnt   <= '0;
         r_comma_cnt <= '0;
         r_state     <= SEARCH;
      end else begin
         r_shift   <= w_byte_nx;
         r_bit_cnt <= r_bit_cnt + 3'd1;
         case (r_state)
            SEARCH: begin
               // Sliding match: the edge that completes a comma becomes bit 7,
               // so the next edge starts a fresh byte at count 0.
               if (w_is_comma) begin
                  r_bit_cnt   <= 3'd0;
                  r_comma_cnt <= 8'd1;
                  r_state     <= LOCKING;
               end
            end
            LOCKING: begin
               if (w_boundary) begin
                  if (w_is_comma) begin
                     r_comma_cnt <= w_cnt_inc;
                     if (w_cnt_inc == 8'(COMMA_COUNT)) begin
                        r_state <= ACTIVE;
                     end
                  end else begin
                     r_comma_cnt <= 8'd0;
                     r_state     <= SEARCH;
                  end
               end
            end
            ACTIVE: begin
               // Locked until reset; commas here are ordinary line bytes
            end
            default: r_state <= SEARCH;
         endcase
      end
   end

   assign o_rx_byte  = w_byte_nx;
   assign o_boundary = w_boundary;
   assign o_active   = (r_state == ACTIVE);

endmodule

// File: rtl/phy_rx_deserializer.sv
// rtl/phy_rx_deserializer.sv - two-lane PHY receive deserializer top
//
// Purpose: aligns the serial link through phy_rx_aligner, then splits the
//          interleaved byte stream into lane 0 / lane 1 bytes with valid flags,
//          presenting one registered pair every 16 bit clocks.
// Optional: PHY_RX_LANE_STATS_EN adds saturating per-lane valid byte counters.
// Ports:
//   clk_8f       in   bit clock
//   reset        in   asynchronous active-low reset
//   data_in      in   serial data, MSB first
//   data_out_0   out  lane 0 byte
//   valid_out_0  out  lane 0 byte is payload
//   data_out_1   out  lane 1 byte
//   valid_out_1  out  lane 1 byte is payload
//   pair_strobe  out  one-cycle pulse per new pair
//   active       out  link aligned
//   valid_cnt_0  out  lane 0 valid byte count (PHY_RX_LANE_STATS_EN only)
//   valid_cnt_1  out  lane 1 valid byte count (PHY_RX_LANE_STATS_EN only)
module phy_rx_deserializer
   import phy_pkg::*;
#(
   parameter logic [BYTE_W-1:0] COMMA       = COMMA_DEF,
   parameter logic [BYTE_W-1:0] IDLE        = IDLE_DEF,
   parameter int unsigned       COMMA_COUNT = 4
) (
   input  logic              clk_8f,
   input  logic              reset,
   input  logic              data_in,
   output logic [BYTE_W-1:0] data_out_0,
   output logic              valid_out_0,
   output logic [BYTE_W-1:0] data_out_1,
   output logic              valid_out_1,
   output logic              pair_strobe,
`ifdef PHY_RX_LANE_STATS_EN
   output logic [7:0]        valid_cnt_0,
   output logic [7:0]        valid_cnt_1,
`endif
   output logic              active
);

   logic [BYTE_W-1:0] w_rx_byte;
   logic              w_boundary;
   logic              w_active;
   logic              w_pair;
   logic              w_v0;
   logic              w_v1;

   logic              r_slot;
   logic [BYTE_W-1:0] r_stage;
   logic [BYTE_W-1:0] r_data_0;
   logic [BYTE_W-1:0] r_data_1;
   logic              r_valid_0;
   logic              r_valid_1;
   logic              r_strobe;

   phy_rx_aligner #(
      .COMMA       (COMMA),
      .COMMA_COUNT (COMMA_COUNT)
   ) u_aligner (
      .clk_8f     (clk_8f),
      .rst_n      (reset),
      .i_data     (data_in),
      .o_rx_byte  (w_rx_byte),
      .o_boundary (w_boundary),
      .o_active   (w_active)
   );

   // The boundary that moves the aligner into ACTIVE sees w_active still low,
   // so slot 0 is always the first byte after the final lock comma.
   assign w_pair = w_active && w_boundary && r_slot;
   assign w_v0   = is_data(r_stage, COMMA, IDLE);
   assign w_v1   = is_data(w_rx_byte, COMMA, IDLE);

   always_ff @(posedge clk_8f or negedge reset) begin
      if (!reset) begin
         r_slot    <= 1'b0;
         r_stage   <= '0;
         r_data_0  <= '0;
         r_data_1  <= '0;
         r_valid_0 <= 1'b0;
         r_valid_1 <= 1'b0;
         r_strobe  <= 1'b0;
      end else begin
         r_strobe <= 1'b0;
         if (w_active && w_boundary) begin
            if (!r_slot) begin
               r_stage <= w_rx_byte;
               r_slot  <= 1'b1;
            end else begin
               r_data_0  <= r_stage;
               r_data_1  <= w_rx_byte;
               r_valid_0 <= w_v0;
               r_valid_1 <= w_v1;
               r_strobe  <= 1'b1;
               r_slot    <= 1'b0;
            end
         end
      end
   end

`ifdef PHY_RX_LANE_STATS_EN
   logic [7:0] r_cnt_0;
   logic [7:0] r_cnt_1;

   always_ff @(posedge clk_8f or negedge reset) begin
      if (!reset) begin
         r_cnt_0 <= '0;
         r_cnt_1 <= '0;
      end else if (w_pair) begin
         if (w_v0 && (r_cnt_0 != 8'hFF)) r_cnt_0 <= r_cnt_0 + 8'd1;
         if (w_v1 && (r_cnt_1 != 8'hFF)) r_cnt_1 <= r_cnt_1 + 8'd1;
      end
   end

   assign valid_cnt_0 = r_cnt_0;
   assign valid_cnt_1 = r_cnt_1;
`endif

   assign data_out_0  = r_data_0;
   assign data_out_1  = r_data_1;
   assign valid_out_0 = r_valid_0;
   assign valid_out_1 = r_valid_1;
   assign pair_strobe = r_strobe;
   assign active      = w_active;

endmodule

// File: tb/tb_phy_rx_deserializer.sv
// tb/tb_phy_rx_deserializer.sv - scoreboard bench for phy_rx_deserializer
module tb_phy_rx_deserializer;

   logic       clk_8f;
   logic       reset;
   logic       data_in;
   logic [7:0] data_out_0;
   logic       valid_out_0;
   logic [7:0] data_out_1;
   logic       valid_out_1;
   logic       pair_strobe;
   logic       active;
`ifdef PHY_RX_LANE_STATS_EN
   logic [7:0] valid_cnt_0;
   logic [7:0] valid_cnt_1;
`endif

   typedef struct packed {
      logic [7:0] d0;
      logic [7:0] d1;
      logic       v0;
      logic       v1;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp       = 0;
   int   n_err       = 0;
   int   n_strobe    = 0;
   int   exp_strobes = 0;

   phy_rx_deserializer dut (
      .clk_8f      (clk_8f),
      .reset       (reset),
      .data_in     (data_in),
      .data_out_0  (data_out_0),
      .valid_out_0 (valid_out_0),
      .data_out_1  (data_out_1),
      .valid_out_1 (valid_out_1),
      .pair_strobe (pair_strobe),
`ifdef PHY_RX_LANE_STATS_EN
      .valid_cnt_0 (valid_cnt_0),
      .valid_cnt_1 (valid_cnt_1),
`endif
      .active      (active)
   );

   initial clk_8f = 1'b0;
   always #5 clk_8f = ~clk_8f;

   // Counts every cycle in which the strobe is high
   always @(negedge clk_8f) begin
      if (pair_strobe === 1'b1) n_strobe++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_valid(input logic [7:0] b);
      return (b != 8'hBC) && (b != 8'h7C);
   endfunction

   task automatic send_bit(input logic b);
      @(negedge clk_8f);
      data_in = b;
      @(posedge clk_8f);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   task automatic send_pair(input logic [7:0] d0, input logic [7:0] d1, input logic expect_out);
      exp_t e;
      if (expect_out) begin
         e.d0 = d0; e.d1 = d1; e.v0 = model_valid(d0); e.v1 = model_valid(d1);
         sb_q.push_back(e);
      end
      send_bit(d0[7]);
      chk("strobe_low_between", 32'(pair_strobe), 32'd0);
      chk("strobe_count", 32'(n_strobe), 32'(exp_strobes));
      for (int i = 6; i >= 0; i--) send_bit(d0[i]);
      send_byte(d1);
      if (expect_out) begin
         chk("strobe_at_lane1_lsb", 32'(pair_strobe), 32'd1);
         e = sb_q.pop_front();
         chk("data_out_0", 32'(data_out_0), 32'(e.d0));
         chk("data_out_1", 32'(data_out_1), 32'(e.d1));
         chk("valid_out_0", 32'(valid_out_0), 32'(e.v0));
         chk("valid_out_1", 32'(valid_out_1), 32'(e.v1));
         exp_strobes++;
      end else begin
         chk("no_strobe_unlocked", 32'(pair_strobe), 32'd0);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_d0"}, 32'(data_out_0), 32'd0);
      chk({tag, "_d1"}, 32'(data_out_1), 32'd0);
      chk({tag, "_v0"}, 32'(valid_out_0), 32'd0);
      chk({tag, "_v1"}, 32'(valid_out_1), 32'd0);
      chk({tag, "_strobe"}, 32'(pair_strobe), 32'd0);
      chk({tag, "_active"}, 32'(active), 32'd0);
   endtask

   initial begin
      reset   = 1'b0;
      data_in = 1'b0;

      // Held in reset with random line activity
      for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)));
      chk_all_zero("reset");

      @(negedge clk_8f);
      reset   = 1'b1;
      data_in = 1'b0;

      // Three aligned commas are one short of lock
      repeat (3) send_byte(8'hBC);
      chk("three_commas_inactive", 32'(active), 32'd0);

      // Garbage breaks the partial lock; the hunt then finds the next comma
      repeat (3) send_bit(1'b0);
      repeat (3) send_byte(8'hBC);
      chk("lock_before_fourth", 32'(active), 32'd0);
      send_byte(8'hBC);
      chk("lock_on_fourth_lsb", 32'(active), 32'd1);

      send_pair(8'h7C, 8'h7C, 1'b1);
      send_pair(8'hFF, 8'h00, 1'b1);
      send_pair(8'hEE, 8'h01, 1'b1);
      send_pair(8'hDD, 8'h02, 1'b1);
      send_pair(8'hBB, 8'h7C, 1'b1);
      send_pair(8'hBC, 8'h11, 1'b1);
      chk("comma_no_realign", 32'(active), 32'd1);
      send_pair(8'hAA, 8'h05, 1'b1);

      // Asynchronous reset partway through the next pair
      for (int i = 7; i >= 4; i--) send_bit(1'(8'h5A >> i));
      #1 reset = 1'b0;
      #1 chk_all_zero("async_reset");
      repeat (3) send_bit(1'($urandom_range(0, 1)));
      @(negedge clk_8f);
      reset   = 1'b1;
      data_in = 1'b0;

      send_pair(8'hAA, 8'h05, 1'b0);
      chk("no_lock_after_reset", 32'(active), 32'd0);

      // Two commas then a non-comma at the boundary drops back to the hunt
      send_byte(8'hBC);
      send_byte(8'hBC);
      send_byte(8'hA4);
      chk("locking_abort", 32'(active), 32'd0);

      repeat (3) send_byte(8'hBC);
      chk("relock_before_fourth", 32'(active), 32'd0);
      send_byte(8'hBC);
      chk("relock_on_fourth", 32'(active), 32'd1);
      send_pair(8'h12, 8'h34, 1'b1);
      send_bit(1'b0);
      chk("strobe_one_cycle", 32'(pair_strobe), 32'd0);
      chk("final_strobe_count", 32'(n_strobe), 32'(exp_strobes));
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
`ifdef PHY_RX_LANE_STATS_EN
      chk("valid_cnt_0", 32'(valid_cnt_0), 32'd1);
      chk("valid_cnt_1", 32'(valid_cnt_1), 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/phy_rx_deserializer.md
Name: phy_rx_deserializer

Overview:
Receive end of the two-lane PHY link. Takes the single serial bit stream produced by the transmit-side serializer on the 8f bit clock. Finds byte alignment using the comma character and declares the link active. Splits the interleaved byte stream back into lane 0 and lane 1 bytes, each with a valid flag, for the lane-side logic.

Parameters:
COMMA, 8'hBC, alignment/inactive character; never reported as valid data
IDLE, 8'h7C, active-but-no-data character; never reported as valid data
COMMA_COUNT, 4, consecutive byte-aligned commas needed to enter ACTIVE; must be even and >= 2

Ports:
clk_8f  input  1  bit clock, one serial bit per rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
data_in  input  1  serial data, MSB of each byte first
data_out_0  output  8  lane 0 recovered byte
valid_out_0  output  1  lane 0 byte is data (not COMMA/IDLE)
data_out_1  output  8  lane 1 recovered byte
valid_out_1  output  1  lane 1 byte is data
pair_strobe  output  1  one-cycle pulse when a new lane pair is presented
active  output  1  link aligned (state ACTIVE)

Behaviour:
- Reset (reset=0, async):
  - All outputs 0; shift register 0; bit counter 0; comma counter 0; lane slot 0; state SEARCH.
- Shift register: every edge, byte_nx = {shift_q[6:0], data_in}; shift_q <= byte_nx.
- Bit counter: 3 bits, wraps 7->0. A byte boundary is the edge where bit_cnt==7.
- SEARCH:
  - Bit-level sliding match.
  - If byte_nx==COMMA on any edge: bit_cnt <= 0, comma_cnt <= 1, go to LOCKING.
- LOCKING:
  - At each boundary, if byte_nx==COMMA: comma_cnt++. When it reaches COMMA_COUNT, go to ACTIVE with slot <= 0.
  - At a boundary with any other byte: comma_cnt <= 0, go to SEARCH.
  - Outputs stay 0 in SEARCH and LOCKING.
- ACTIVE (active=1):
  - Slot 0 boundary: byte_nx -> lane-0 staging register; slot <= 1.
  - Slot 1 boundary, on the same edge:
    - data_out_0 <= staging; data_out_1 <= byte_nx.
    - valid_out_x <= (byte != COMMA && byte != IDLE).
    - pair_strobe <= 1 for exactly one cycle; slot <= 0.
  - Outputs hold between strobes, so one pair is presented every 16 clk_8f cycles.
  - COMMA bytes in ACTIVE do not cause realignment. They decode as valid=0 and data_out still shows the raw byte.
  - The block leaves ACTIVE only by reset.
- Latency:
  - Outputs change on the edge that samples the last (LSB) bit of the lane-1 byte.
  - pair_strobe is high in the cycle following that edge.
- Reset mid-operation: immediate clear of everything to the reset values, including a pair that is half received.
- A single comma match that is not confirmed at the next boundary returns to SEARCH. The bit-level hunt then restarts on the following edge.

Optional Feature:
- Macro PHY_RX_LANE_STATS_EN.
- Defined: adds outputs valid_cnt_0[7:0] and valid_cnt_1[7:0].
  - Saturating counts of valid bytes per lane.
  - Increment on pair update when valid_out_x is set; stop at 8'hFF.
  - Reset to 0 on reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package phy_pkg holds:
  - COMMA/IDLE constant defaults;
  - state encoding SEARCH=2'd0, LOCKING=2'd1, ACTIVE=2'd2;
  - BYTE_W=8.
- The package is reused by the serializer side.
- One natural sub-module: phy_rx_aligner. It owns the shift register, bit counter, comma counter and FSM, and exports byte, byte_boundary and active. The top does lane demux and decode.

Test Plan:
- Reset held 0 for 20 cycles with arbitrary data_in -> all outputs 0, active=0. Release, then 3 aligned BC bytes -> still active=0.
- 3 garbage bits, then 4 BC bytes MSB-first -> active=1 on the edge of the 4th BC's LSB. Then pair 7C,7C -> pair_strobe pulse, valid_out_0=valid_out_1=0.
- After lock, send pairs (FF,00), (EE,01), (DD,02) -> data_out_0/1 match, both valid=1, pair_strobe every 16 cycles exactly.
- After lock, pair (BB,7C) -> data_out_0=BB valid_out_0=1; valid_out_1=0, data_out_1=7C.
- BC, BC, then A4 at a boundary during LOCKING -> back to SEARCH, active stays 0. A later 4xBC locks correctly.
- Assert reset=0 mid-pair after (AA,05) was presented -> outputs 0 immediately (asynchronous). After release, no output until relock.
